// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier controller.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ALU_W = 16;

    localparam logic ALU_CTRL_SUB = 1'b0;
    localparam logic ALU_CTRL_ADD = 1'b1;

    // Booth pair codes, {Q[0], Q-1}
    localparam logic [1:0] PAIR_HOLD0 = 2'b00;
    localparam logic [1:0] PAIR_ADD   = 2'b01;
    localparam logic [1:0] PAIR_SUB   = 2'b10;
    localparam logic [1:0] PAIR_HOLD1 = 2'b11;

    // ALU control for a Booth pair; the hold pairs drive add (result unused)
    function automatic logic alu_ctrl_for(input logic [1:0] pair);
        return (pair == PAIR_SUB) ? ALU_CTRL_SUB : ALU_CTRL_ADD;
    endfunction

endpackage

// File: rtl/booth_controller_alu.sv
// Shared 16-bit add/subtract ALU: control=1 adds, control=0 subtracts.
module ALU (
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic        control,
    output logic [15:0] result
);

    // Purely combinational add/sub
    always_comb begin
        result = control ? (in1 + in2) : (in1 - in2);
    end

endmodule

// File: rtl/booth_controller.sv
// Sequential radix-2 Booth multiplier controller driving the shared ALU.
module booth_controller
    import booth_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N + 1);

    state_t          state;
    state_t          state_next;
    logic [N:0]      a;
    logic [N-1:0]    q;
    logic [N-1:0]    m;
    logic            q_m1;
    logic [CW-1:0]   count;

    logic [1:0]       pair;
    logic             alu_ctrl;
    logic [ALU_W-1:0] alu_in1;
    logic [ALU_W-1:0] alu_in2;
    logic [ALU_W-1:0] alu_result;
    logic [ALU_W-1:0] alu_unused;
    logic [N:0]       a_new;
    logic             accept;
    logic             last_iter;

    assign pair      = {q[0], q_m1};
    assign alu_ctrl  = alu_ctrl_for(pair);
    assign alu_in1   = ALU_W'(signed'(a));
    assign alu_in2   = ALU_W'(signed'(m));
    // Only result[N:0] forms the new accumulator
    assign alu_unused = alu_result;
    assign accept    = (state == IDLE) && start;
    assign last_iter = (state == RUN) && (count == CW'(1));

    ALU u_alu (
        .in1     (alu_in1),
        .in2     (alu_in2),
        .control (alu_ctrl),
        .result  (alu_result)
    );

    // Accumulator update: keep ALU result for add/sub pairs, else hold A
    always_comb begin
        a_new = a;
        if (pair == PAIR_ADD || pair == PAIR_SUB) begin
            a_new = alu_result[N:0];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath: capture on accept, add/sub plus arithmetic shift per iteration
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a       <= '0;
            q       <= '0;
            m       <= '0;
            q_m1    <= 1'b0;
            count   <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            done <= last_iter;
            if (accept) begin
                a     <= '0;
                q     <= multiplier;
                q_m1  <= 1'b0;
                m     <= multiplicand;
                count <= CW'(N);
            end else if (state == RUN) begin
                a     <= {a_new[N], a_new[N:1]};
                q     <= {a_new[0], q[N-1:1]};
                q_m1  <= q[0];
                count <= count - CW'(1);
                // {A[N-1:0], Q} after the shift equals {A_new, Q[N-1:1]}
                if (last_iter) begin
                    product <= {a_new, q[N-1:1]};
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_controller.sv
// Self-checking bench for booth_controller: scoreboard against a signed-multiply model.
module tb_booth_controller;

    localparam int N  = 8;
    localparam int PW = 2 * N;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  multiplicand;
    logic [N-1:0]  multiplier;
    logic          busy;
    logic          done;
    logic [PW-1:0] product;

    booth_controller #(.N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard and protocol model state
    logic [PW-1:0] sb[$];
    int            m_phase;   // cycles of busy remaining; 1 means done cycle
    logic          m_flush;
    int            tests;
    int            fails;
    logic          end_req;
    logic          end_done;
    logic [PW-1:0] exp_hold;

    function automatic logic [PW-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y);
        int sx;
        int sy;
        sx = int'($signed(x));
        sy = int'($signed(y));
        return PW'(sx * sy);
    endfunction

    // Protocol model: accept in idle, busy for N+1 cycles, done on the last
    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_flush <= 1'b1;
        end else begin
            m_flush <= 1'b0;
            if (m_phase == 0) begin
                if (start) begin
                    sb.push_back(ref_mul(multiplicand, multiplier));
                    m_phase <= N + 1;
                end
            end else begin
                m_phase <= m_phase - 1;
            end
        end
    end

    // Monitor: compare DUT outputs against the model away from the active edge
    initial begin
        tests    = 0;
        fails    = 0;
        end_done = 1'b0;
        exp_hold = '0;
    end

    always @(negedge clk) begin
        if (m_flush) begin
            sb.delete();
            exp_hold = '0;
        end
        tests++;
        if (busy !== (m_phase != 0)) begin
            fails++;
            $display("FAIL busy t=%0t actual=%b required=%b", $time, busy, (m_phase != 0));
        end
        tests++;
        if (done !== (m_phase == 1)) begin
            fails++;
            $display("FAIL done t=%0t actual=%b required=%b", $time, done, (m_phase == 1));
        end
        if (m_phase == 1 || done === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done t=%0t product=%h", $time, product);
            end else begin
                exp_hold = sb.pop_front();
            end
        end
        tests++;
        if (product !== exp_hold) begin
            fails++;
            $display("FAIL product t=%0t actual=%h required=%h", $time, product, exp_hold);
        end
        if (end_req && !end_done) begin
            end_done = 1'b1;
            tests++;
            if (sb.size() != 0) begin
                fails++;
                $display("FAIL drain actual=%0d pending required=0", sb.size());
            end
        end
    end

    task automatic wait_idle();
        int unsigned k;
        k = 0;
        while (m_phase != 0 && k < 64) begin
            @(negedge clk);
            k++;
        end
        if (m_phase != 0) begin
            $display("FAIL idle_timeout actual=busy required=idle");
            $fatal(1, "idle timeout");
        end
    endtask

    task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y);
        wait_idle();
        multiplicand = x;
        multiplier   = y;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    logic [N-1:0] dir_m[6] = '{8'h07, 8'hF9, 8'h03, 8'h80, 8'h7F, 8'h00};
    logic [N-1:0] dir_q[6] = '{8'h03, 8'h03, 8'hF9, 8'h80, 8'h80, 8'hFF};

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        end_req      = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed operands including extremes
        for (int i = 0; i < 6; i++) begin
            issue(dir_m[i], dir_q[i]);
        end

        // Start pulses mid-RUN and during DONE must be ignored
        issue(8'h07, 8'h03);
        repeat (3) @(negedge clk);
        multiplicand = 8'h55;
        multiplier   = 8'h66;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        for (int k = 0; k < 32 && m_phase != 1; k++) @(negedge clk);
        multiplicand = 8'h11;
        multiplier   = 8'h22;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        repeat (3) @(negedge clk);

        // Start held high: back-to-back accepts
        wait_idle();
        start = 1'b1;
        for (int k = 0; k < 35; k++) begin
            multiplicand = N'($urandom);
            multiplier   = N'($urandom);
            @(negedge clk);
        end
        start = 1'b0;

        // Reset in the middle of an operation, then a fresh 5x5
        issue(8'h5A, 8'hC3);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        issue(8'h05, 8'h05);

        // Random signed pairs
        for (int i = 0; i < 1000; i++) begin
            issue(N'($urandom), N'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        wait_idle();
        repeat (2) @(negedge clk);
        end_req = 1'b1;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/booth_controller.md
# booth_controller

- Sequential radix-2 Booth multiplier controller: signed N×N operands in, signed 2N-bit product out.
- Multi-cycle; sequences the team's 16-bit add/subtract ALU (module `ALU`) once per multiplier bit, then applies an arithmetic right shift each iteration.
- Sits between a requester issuing single-shot multiply commands and the shared add/sub datapath.

## Interface
- N, default 8, operand width in bits. Legal range 2..15, so the N+1-bit accumulator fits the 16-bit ALU.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request strobe; sampled only in IDLE.
- multiplicand  input  N  signed operand M; captured on accept.
- multiplier  input  N  signed operand Q; captured on accept.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse; product valid.
- product  output  2N  signed result; held until the next accept.

## Operation
- **States**
  - IDLE: wait for start.
  - RUN: N iterations.
  - DONE: one cycle, then IDLE.
- **Accept** (IDLE, start=1 at an edge):
  - A(N+1 bits) ← 0; Q ← multiplier; Q₋₁ ← 0; M ← multiplicand; count ← N; state ← RUN.
  - product is not cleared on accept.
- **RUN iteration** (one per clock), decode {Q[0],Q₋₁}:
  - 01: A ← A + M, ALU control=1.
  - 10: A ← A − M, ALU control=0.
  - 00 or 11: A unchanged; control is don't-care and is driven to 1.
- **ALU use**
  - in1 = A sign-extended to 16 bits; in2 = M sign-extended to 16 bits.
  - Keep result[N:0] as the new A; upper ALU bits are ignored.
- **Shift and count**
  - Same edge: {A,Q,Q₋₁} ← arithmetic right shift by 1 of {A_new,Q,Q₋₁}; A's MSB is replicated.
  - count decrements each iteration.
- **Completion**
  - On the iteration where count reaches 0: product ← {A[N-1:0],Q} post-shift; state ← DONE.
- **DONE**
  - done=1 for exactly one cycle; next edge → IDLE.
  - start during DONE is ignored.
- **Ignored start**: start in RUN or DONE has no effect. Operands are not re-sampled mid-operation.
- **Range**: −2^(N−1) × −2^(N−1) is exact; the N+1-bit accumulator prevents overflow when M = −2^(N−1).

## Timing
- **Reset**: rst_n=0 at any edge, including mid-RUN, forces:
  - state=IDLE, busy=0, done=0, product=0, all internal registers=0.
  - The in-flight operation is discarded, with no done pulse.
- **Latency**
  - Accept at edge k → busy=1 from edge k.
  - done=1 and product valid during the cycle after edge k+N.
  - IDLE (busy=0) after edge k+N+1.
- **Throughput**: one multiply per N+2 cycles. Earliest next accept is edge k+N+2, with start held high.
- **Output registers**: done and product are registered; no combinational path from start to outputs.
- **busy**: fully decoded from state; 0 in IDLE, 1 in RUN and DONE.

## Structure
- **Package `booth_pkg`**
  - state enum {IDLE, RUN, DONE}.
  - ALU_W=16.
  - ALU_CTRL_SUB=1'b0, ALU_CTRL_ADD=1'b1.
  - Booth pair codes.
- **Sub-module**: one instance of the existing combinational `ALU` (ports in1, in2, control, result), unmodified.
- **Registers in controller**: A, Q, Q₋₁, M, count ($clog2(N+1) bits), state, product, done.

## Test plan
- **Basic positive**: N=8, M=7, Q=3, start one cycle → done exactly 8 cycles after accept; product=16'h0015; busy high 9 cycles.
- **Negative operand**: M=−7 (8'hF9), Q=3 → product=16'hFFEB (−21). M=3, Q=−7 → same product.
- **Extremes**
  - M=−128, Q=−128 → 16'h4000.
  - M=127, Q=−128 → 16'hC080.
  - M=0, Q=−1 → 16'h0000.
- **Protocol**
  - Pulse start with new operands mid-RUN and again during DONE → ignored; first result unchanged.
  - Hold start high continuously → back-to-back accepts every 10 cycles.
  - product stays stable between done pulses.
- **Reset mid-operation**: assert rst_n=0 for one edge at iteration 4 → busy=0, product=0, no done. A fresh 5×5 then yields 16'h0019.
- **Random**: 1000 random signed pairs checked against a signed reference product; each done is exactly one cycle wide.
